// File: rtl/uart_tx_arbiter_if.sv
// ============================================================================
// Module  : uart_tx_arbiter_if
// Brief   : Requester-side and UART-side handshake bundle for uart_tx_arbiter.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

interface uart_tx_arbiter_if #(
  parameter int NBIT_DATA_LEN = 8,
  parameter int N_REQ         = 4
);
  logic [N_REQ-1:0]               req;
  logic [N_REQ*NBIT_DATA_LEN-1:0] req_data;
  logic [N_REQ-1:0]               req_last;
  logic                           tx_done_tick;
  logic [N_REQ-1:0]               grant;
  logic [N_REQ-1:0]               byte_ack;
  logic                           tx_start;
  logic [NBIT_DATA_LEN-1:0]       tx_data;

  modport master (
    input  req, req_data, req_last, tx_done_tick,
    output grant, byte_ack, tx_start, tx_data
  );

  modport slave (
    output req, req_data, req_last, tx_done_tick,
    input  grant, byte_ack, tx_start, tx_data
  );
endinterface

`default_nettype wire

// File: rtl/uart_tx_arbiter.sv
// ============================================================================
// Module  : uart_tx_arbiter
// Brief   : Burst-granting arbiter sharing one UART TX among N_REQ byte streams.
//           Define ARB_FIXED_PRIO_EN for lowest-index-wins; round-robin otherwise.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_tx_arbiter #(
  parameter int NBIT_DATA_LEN = 8,
  parameter int N_REQ         = 4,
  parameter int MAX_BURST     = 16
) (
  input  logic                clk,
  input  logic                reset,
  uart_tx_arbiter_if.master   bus,
  output logic                busy
);

  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int CNT_W = $clog2(MAX_BURST + 1);
  localparam logic [CNT_W-1:0] C_MAX_BURST = CNT_W'(MAX_BURST);
  localparam logic [IDX_W-1:0] C_LAST_IDX  = IDX_W'(N_REQ - 1);

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_LOAD      = 2'd1,
    ST_WAIT_DONE = 2'd2
  } state_t;

  state_t                   r_state, w_state_nxt;
  logic [N_REQ-1:0]         r_grant, w_grant_nxt;
  logic [N_REQ-1:0]         r_byte_ack, w_byte_ack_nxt;
  logic                     r_tx_start, w_tx_start_nxt;
  logic [NBIT_DATA_LEN-1:0] r_tx_data, w_tx_data_nxt;
  logic [IDX_W-1:0]         r_rr_ptr, w_rr_ptr_nxt;
  logic [CNT_W-1:0]         r_burst_cnt, w_burst_cnt_nxt;
  logic [IDX_W-1:0]         r_owner, w_owner_nxt;
  logic                     r_last_q, w_last_q_nxt;
  logic                     r_done_q;
  logic                     w_done_edge;
  logic                     w_release;
  logic [IDX_W-1:0]         w_winner;
  int                       w_scan_idx;

  assign w_done_edge = bus.tx_done_tick & ~r_done_q;
  assign w_release   = r_last_q | (r_burst_cnt == C_MAX_BURST) | ~bus.req[r_owner];

  // Descending scan so the highest-priority candidate is the last one written.
  always_comb begin
    w_winner   = '0;
    w_scan_idx = 0;
`ifdef ARB_FIXED_PRIO_EN
    for (int k = N_REQ - 1; k >= 0; k--) begin
      if (bus.req[k]) w_winner = IDX_W'(k);
    end
`else
    for (int k = N_REQ - 1; k >= 0; k--) begin
      w_scan_idx = int'(r_rr_ptr) + k;
      if (w_scan_idx >= N_REQ) w_scan_idx = w_scan_idx - N_REQ;
      if (bus.req[w_scan_idx]) w_winner = IDX_W'(w_scan_idx);
    end
`endif
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_grant_nxt     = r_grant;
    w_byte_ack_nxt  = '0;
    w_tx_start_nxt  = 1'b0;
    w_tx_data_nxt   = r_tx_data;
    w_rr_ptr_nxt    = r_rr_ptr;
    w_burst_cnt_nxt = r_burst_cnt;
    w_owner_nxt     = r_owner;
    w_last_q_nxt    = r_last_q;
    case (r_state)
      ST_IDLE: begin
        if (|bus.req) begin
          w_owner_nxt     = w_winner;
          w_grant_nxt     = N_REQ'(1) << w_winner;
          w_burst_cnt_nxt = '0;
          w_state_nxt     = ST_LOAD;
        end
      end
      ST_LOAD: begin
        w_tx_data_nxt            = bus.req_data[r_owner*NBIT_DATA_LEN +: NBIT_DATA_LEN];
        w_last_q_nxt             = bus.req_last[r_owner];
        w_tx_start_nxt           = 1'b1;
        w_byte_ack_nxt           = N_REQ'(1) << r_owner;
        w_burst_cnt_nxt          = r_burst_cnt + 1'b1;
        w_state_nxt              = ST_WAIT_DONE;
      end
      ST_WAIT_DONE: begin
        if (w_done_edge) begin
          if (w_release) begin
            w_grant_nxt = '0;
`ifdef ARB_FIXED_PRIO_EN
            w_rr_ptr_nxt = '0;
`else
            w_rr_ptr_nxt = (r_owner == C_LAST_IDX) ? '0 : r_owner + 1'b1;
`endif
            w_state_nxt = ST_IDLE;
          end else begin
            w_state_nxt = ST_LOAD;
          end
        end
      end
      default: begin
        w_state_nxt     = ST_IDLE;
        w_grant_nxt     = '0;
        w_tx_data_nxt   = '0;
        w_burst_cnt_nxt = '0;
        w_owner_nxt     = '0;
        w_last_q_nxt    = 1'b0;
      end
    endcase
  end

  // The done history is kept through reset so a level held across reset is not seen as an edge.
  always_ff @(posedge clk) begin
    r_done_q <= bus.tx_done_tick;
    if (reset) begin
      r_state     <= ST_IDLE;
      r_grant     <= '0;
      r_byte_ack  <= '0;
      r_tx_start  <= 1'b0;
      r_tx_data   <= '0;
      r_rr_ptr    <= '0;
      r_burst_cnt <= '0;
      r_owner     <= '0;
      r_last_q    <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_grant     <= w_grant_nxt;
      r_byte_ack  <= w_byte_ack_nxt;
      r_tx_start  <= w_tx_start_nxt;
      r_tx_data   <= w_tx_data_nxt;
      r_rr_ptr    <= w_rr_ptr_nxt;
      r_burst_cnt <= w_burst_cnt_nxt;
      r_owner     <= w_owner_nxt;
      r_last_q    <= w_last_q_nxt;
    end
  end

  assign bus.grant    = r_grant;
  assign bus.byte_ack = r_byte_ack;
  assign bus.tx_start = r_tx_start;
  assign bus.tx_data  = r_tx_data;
  assign busy         = (r_state != ST_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_uart_tx_arbiter.sv
// ============================================================================
// Module  : tb_uart_tx_arbiter
// Brief   : Randomized bench for uart_tx_arbiter with a frame-level reference model.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_uart_tx_arbiter;
  localparam int NB = 8;
  localparam int NR = 4;
  localparam int MB = 16;

  logic clk = 1'b0;
  logic reset;
  logic busy;

  always #5 clk = ~clk;

  uart_tx_arbiter_if #(.NBIT_DATA_LEN(NB), .N_REQ(NR)) bus ();

  uart_tx_arbiter #(.NBIT_DATA_LEN(NB), .N_REQ(NR), .MAX_BURST(MB)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus),
    .busy  (busy)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // Requester byte stores: {last, data}
  logic [8:0]  rq_mem [NR][128];
  int          rq_hd [NR];
  int          rq_tl [NR];
  int          model_rr;
  logic [11:0] exp_q [$];
  int          done_cnt, hold_cnt, hold_force;
  bit          done_rise_now, spurious_en;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
  endtask

  function automatic bit all_empty();
    for (int i = 0; i < NR; i++) if (rq_hd[i] < rq_tl[i]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic drive_reqs();
    for (int i = 0; i < NR; i++) begin
      if (rq_hd[i] < rq_tl[i]) begin
        bus.req[i]               = 1'b1;
        bus.req_data[i*NB +: NB] = rq_mem[i][rq_hd[i]][7:0];
        bus.req_last[i]          = rq_mem[i][rq_hd[i]][8];
      end else begin
        bus.req[i]               = 1'b0;
        bus.req_data[i*NB +: NB] = NB'($urandom);
        bus.req_last[i]          = 1'($urandom);
      end
    end
  endtask

  task automatic push_byte(input int r, input logic [7:0] d, input bit last);
    if (rq_hd[r] == rq_tl[r]) begin rq_hd[r] = 0; rq_tl[r] = 0; end
    rq_mem[r][rq_tl[r]] = {last, d};
    rq_tl[r]++;
  endtask

  task automatic push_frame(input int r, input int len, input bit last_end);
    for (int k = 0; k < len; k++) push_byte(r, 8'($urandom), last_end && (k == len - 1));
  endtask

  // Frame-level prediction of the byte order the UART must see.
  task automatic run_model();
    int hd [NR];
    int w, cnt, j;
    bit any;
    logic [8:0] e;
    for (int i = 0; i < NR; i++) hd[i] = rq_hd[i];
    forever begin
      any = 1'b0;
      for (int i = 0; i < NR; i++) if (hd[i] < rq_tl[i]) any = 1'b1;
      if (!any) break;
      w = -1;
      for (int k = 0; k < NR; k++) begin
`ifdef ARB_FIXED_PRIO_EN
        j = k;
`else
        j = (model_rr + k) % NR;
`endif
        if (w < 0 && hd[j] < rq_tl[j]) w = j;
      end
      cnt = 0;
      do begin
        e = rq_mem[w][hd[w]];
        hd[w]++;
        cnt++;
        exp_q.push_back({4'(w), e[7:0]});
      end while (!(e[8] || cnt == MB || hd[w] == rq_tl[w]));
`ifdef ARB_FIXED_PRIO_EN
      model_rr = 0;
`else
      model_rr = (w + 1) % NR;
`endif
    end
  endtask

  task automatic tick();
    logic [11:0]   e;
    logic [NR-1:0] oh;
    @(posedge clk);
    #1;
    done_rise_now = 1'b0;
    if (bus.tx_start) begin
      if (exp_q.size() == 0) begin
        check("unexpected_start", 32'd1, 32'd0);
      end else begin
        e  = exp_q.pop_front();
        oh = NR'(1) << e[11:8];
        check("grant_at_start", 32'(bus.grant), 32'(oh));
        check("byte_ack", 32'(bus.byte_ack), 32'(oh));
        check("tx_data", 32'(bus.tx_data), 32'(e[7:0]));
      end
      done_cnt = $urandom_range(6, 12);
    end else begin
      check("ack_without_start", 32'(bus.byte_ack), 32'd0);
    end
    check("busy_vs_grant", 32'(busy), 32'(|bus.grant));
    for (int i = 0; i < NR; i++)
      if (bus.byte_ack[i] && rq_hd[i] < rq_tl[i]) rq_hd[i]++;
    // UART model: rises after a delay, held high for a few cycles
    if (hold_cnt > 0) begin
      hold_cnt--;
      if (hold_cnt == 0) bus.tx_done_tick = 1'b0;
    end
    if (done_cnt > 0) begin
      done_cnt--;
      if (done_cnt == 0) begin
        bus.tx_done_tick = 1'b1;
        hold_cnt = (hold_force > 0) ? hold_force : $urandom_range(1, 5);
        done_rise_now = 1'b1;
      end
    end else if (hold_cnt == 0 && !busy && spurious_en && $urandom_range(0, 15) == 0) begin
      bus.tx_done_tick = 1'b1;
      hold_cnt = 1;
    end
    drive_reqs();
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while (!(all_empty() && exp_q.size() == 0 && !busy && done_cnt == 0 && hold_cnt == 0)
           && n < budget) begin
      tick();
      n++;
    end
    check("idle_timeout", 32'(n < budget), 32'd1);
    check("exp_left", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    for (int i = 0; i < NR; i++) rq_hd[i] = rq_tl[i];
    exp_q.delete();
    done_cnt = 0;
    hold_cnt = 0;
    bus.tx_done_tick = 1'b0;
    drive_reqs();
    tick();
    tick();
    reset = 1'b0;
    model_rr = 0;
  endtask

  initial begin
    int n;
    reset = 1'b1;
    bus.req = '0;
    bus.req_data = '0;
    bus.req_last = '0;
    bus.tx_done_tick = 1'b0;
    for (int i = 0; i < NR; i++) begin rq_hd[i] = 0; rq_tl[i] = 0; end
    done_cnt = 0; hold_cnt = 0; hold_force = 0; spurious_en = 1'b0; model_rr = 0;
    tick();
    tick();
    check("rst_grant", 32'(bus.grant), 32'd0);
    check("rst_tx_start", 32'(bus.tx_start), 32'd0);
    check("rst_byte_ack", 32'(bus.byte_ack), 32'd0);
    check("rst_tx_data", 32'(bus.tx_data), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    reset = 1'b0;

    // Single requester latency and release timing
    push_byte(1, 8'hA5, 1'b1);
    run_model();
    drive_reqs();
    tick();
    check("t1_grant_t1", 32'(bus.grant), 32'h2);
    check("t1_no_start_t1", 32'(bus.tx_start), 32'd0);
    tick();
    check("t1_start_t2", 32'(bus.tx_start), 32'd1);
    n = 0;
    while (!done_rise_now && n < 30) begin tick(); n++; end
    check("t1_done_seen", 32'(done_rise_now), 32'd1);
    tick();
    check("t1_release", 32'(bus.grant), 32'd0);
    wait_idle(200);

    // Pointer left at 2: requesters 0,1,3 then served in scan order from 2
    push_byte(0, 8'h30, 1'b1);
    push_byte(1, 8'h31, 1'b1);
    push_byte(3, 8'h33, 1'b1);
    run_model();
    drive_reqs();
    wait_idle(500);

    // Four one-byte frames, twice
    do_reset();
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < NR; i++) push_byte(i, 8'(8'h10 + i), 1'b1);
      run_model();
      drive_reqs();
      wait_idle(1000);
    end

    // Long stream forced to release at MAX_BURST
    do_reset();
    push_frame(0, 20, 1'b1);
    push_frame(2, 3, 1'b1);
    run_model();
    drive_reqs();
    wait_idle(2000);

    // Owner drops request after third byte, long done pulses
    hold_force = 5;
    push_frame(1, 3, 1'b0);
    run_model();
    drive_reqs();
    wait_idle(500);
    for (int k = 0; k < 20; k++) tick();
    hold_force = 0;

    // Reset mid-byte; late done edge must be ignored
    do_reset();
    push_frame(0, 5, 1'b1);
    run_model();
    drive_reqs();
    n = 0;
    while (!bus.tx_start && n < 20) begin tick(); n++; end
    check("t5_start_seen", 32'(bus.tx_start), 32'd1);
    tick();
    tick();
    reset = 1'b1;
    for (int i = 0; i < NR; i++) rq_hd[i] = rq_tl[i];
    exp_q.delete();
    done_cnt = 0;
    hold_cnt = 0;
    bus.tx_done_tick = 1'b0;
    drive_reqs();
    tick();
    tick();
    reset = 1'b0;
    model_rr = 0;
    done_cnt = 2;
    for (int k = 0; k < 12; k++) begin
      tick();
      check("t5_no_start", 32'(bus.tx_start), 32'd0);
      check("t5_grant", 32'(bus.grant), 32'd0);
      check("t5_busy", 32'(busy), 32'd0);
    end

    // Randomized rounds with stray done pulses while idle
    spurious_en = 1'b1;
    for (int r = 0; r < 20; r++) begin
      for (int i = 0; i < NR; i++) begin
        int nf;
        nf = $urandom_range(0, 2);
        for (int f = 0; f < nf; f++)
          push_frame(i, ($urandom_range(0, 3) == 0) ? $urandom_range(14, 20) : $urandom_range(1, 5),
                     $urandom_range(0, 4) != 0);
      end
      run_model();
      drive_reqs();
      wait_idle(6000);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

`default_nettype wire
